// File: rtl/sar_search_pkg.sv
// Shared types and helpers for the successive-approximation search engine.
// Holds the state encoding, the default width and the one-hot result check.
package sar_pkg;

  localparam int SAR_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } sar_state_t;

  // A legal comparator answer asserts exactly one of gt/lt/eq.
  function automatic logic cmp_onehot(input logic gt, input logic lt, input logic eq);
    case ({gt, lt, eq})
      3'b100, 3'b010, 3'b001: return 1'b1;
      default:                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sar_search_if.sv
// Bundle between the search engine and its environment: start/status plus the
// comparator bus (guess out to comparator input a, gt/lt/eq back).
interface sar_search_if
  import sar_pkg::*;
#(
  parameter int WIDTH  = SAR_WIDTH,
  parameter int STEP_W = 5
);
  logic              start;
  logic              gt;
  logic              lt;
  logic              eq;
  logic [WIDTH-1:0]  guess;
  logic [WIDTH-1:0]  result;
  logic              busy;
  logic              done;
  logic              found;
  logic              cmp_err;
  logic [STEP_W-1:0] steps;

  modport master (
    input  start, gt, lt, eq,
    output guess, result, busy, done, found, cmp_err, steps
  );

  modport slave (
    output start, gt, lt, eq,
    input  guess, result, busy, done, found, cmp_err, steps
  );
endinterface

// File: rtl/sar_search.sv
// Successive-approximation search: walks guess MSB-first against an external
// magnitude comparator and reports the recovered target, step count and errors.
module sar_search
  import sar_pkg::*;
#(
  parameter int WIDTH  = SAR_WIDTH,
  parameter int STEP_W = 5
) (
  input  logic        clk,
  input  logic        n_rst,
  sar_search_if.master bus
);

  localparam int IDX_W = $clog2(WIDTH);

  sar_state_t        state_reg, state_next;
  logic [WIDTH-1:0]  guess_reg, guess_next;
  logic [WIDTH-1:0]  result_reg, result_next;
  logic [IDX_W-1:0]  idx_reg, idx_next;
  logic [STEP_W-1:0] steps_reg, steps_next;
  logic              found_reg, found_next;
  logic              err_reg, err_next;
  logic [WIDTH-1:0]  trial;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_reg  <= IDLE;
      guess_reg  <= '0;
      result_reg <= '0;
      idx_reg    <= '0;
      steps_reg  <= '0;
      found_reg  <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      guess_reg  <= guess_next;
      result_reg <= result_next;
      idx_reg    <= idx_next;
      steps_reg  <= steps_next;
      found_reg  <= found_next;
      err_reg    <= err_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    guess_next  = guess_reg;
    result_next = result_reg;
    idx_next    = idx_reg;
    steps_next  = steps_reg;
    found_next  = found_reg;
    err_next    = err_reg;
    trial       = guess_reg;

    case (state_reg)
      SEARCH: begin
        if (steps_reg != STEP_W'(WIDTH)) begin
          steps_next = steps_reg + STEP_W'(1);
        end
        if (!cmp_onehot(bus.gt, bus.lt, bus.eq)) begin
          err_next    = 1'b1;
          found_next  = 1'b0;
          result_next = guess_reg;
          state_next  = DONE;
        end else if (bus.eq) begin
          found_next  = 1'b1;
          result_next = guess_reg;
          state_next  = DONE;
        end else if (idx_reg == '0) begin
          // Last bit decided without an exact hit: only the LSB may still need clearing.
          result_next = bus.gt ? {guess_reg[WIDTH-1:1], 1'b0} : guess_reg;
          found_next  = 1'b0;
          state_next  = DONE;
        end else begin
          if (bus.gt) begin
            trial[idx_reg] = 1'b0;
          end
          trial[idx_reg - IDX_W'(1)] = 1'b1;
          guess_next = trial;
          idx_next   = idx_reg - IDX_W'(1);
        end
      end
      default: begin
        // IDLE and DONE both accept a new search; result stays until it ends.
        if (bus.start) begin
          state_next = SEARCH;
          guess_next = {1'b1, {(WIDTH-1){1'b0}}};
          idx_next   = IDX_W'(WIDTH - 1);
          steps_next = '0;
          found_next = 1'b0;
          err_next   = 1'b0;
        end
      end
    endcase
  end

  assign bus.guess   = guess_reg;
  assign bus.result  = result_reg;
  assign bus.busy    = (state_reg == SEARCH);
  assign bus.done    = (state_reg == DONE);
  assign bus.found   = found_reg;
  assign bus.cmp_err = err_reg;
  assign bus.steps   = steps_reg;

endmodule
